// File: rtl/rpn_pkg.sv
// Shared constants, control-strobe bundle and strobe decoder for the RPN sequencer.
package rpn_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_PUSH_L = 3'd1;
  localparam logic [2:0] ST_POP_A  = 3'd2;
  localparam logic [2:0] ST_POP_B  = 3'd3;
  localparam logic [2:0] ST_PUSH_R = 3'd4;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  localparam logic SEL_LIT = 1'b0;
  localparam logic SEL_RES = 1'b1;

  typedef struct packed {
    logic stk_push;
    logic stk_pop;
    logic reg1_en;
    logic reg2_en;
    logic mux_sel;
    logic result_valid;
  } ctrl_t;

  // Moore decode: every datapath strobe is a pure function of the state.
  function automatic ctrl_t decode_ctrl(input logic [2:0] st);
    ctrl_t c;
    c = '0;
    c.mux_sel = SEL_LIT;
    case (st)
      ST_PUSH_L: c.stk_push = 1'b1;
      ST_POP_A: begin
        c.reg1_en = 1'b1;
        c.stk_pop = 1'b1;
      end
      ST_POP_B: begin
        c.reg2_en = 1'b1;
        c.stk_pop = 1'b1;
      end
      ST_PUSH_R: begin
        c.stk_push     = 1'b1;
        c.mux_sel      = SEL_RES;
        c.result_valid = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/rpn_depth_counter.sv
// Saturating up/down count of live stack entries, with the compares the sequencer needs.
module rpn_depth_counter
  import rpn_pkg::*;
#(
  parameter int CNT_W     = 6,
  parameter int MAX_COUNT = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             is_empty,
  output logic             lt2,
  output logic             is_full
);

  assign is_empty = (count == '0);
  assign lt2      = (count < CNT_W'(2));
  assign is_full  = (count == CNT_W'(MAX_COUNT));

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && !dec && !is_full) begin
      count <= count + 1'b1;
    end else if (dec && !inc && !is_empty) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/rpn_sequencer.sv
// Token-driven controller for the 4-bit RPN datapath: expands literals and operators
// into push/pop/capture strobes and guards the stack against under/overflow.
module rpn_sequencer
  import rpn_pkg::*;
#(
  parameter int DATA_WIDTH  = 4,
  parameter int STACK_DEPTH = 32,
  parameter int CNT_W       = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tok_valid,
  output logic                  tok_ready,
  input  logic                  tok_is_op,
  input  logic [1:0]            tok_opcode,
  input  logic [DATA_WIDTH-1:0] tok_data,
  output logic                  stk_push,
  output logic                  stk_pop,
  output logic                  reg1_en,
  output logic                  reg2_en,
  output logic                  mux_sel,
  output logic [1:0]            alu_opcode,
  output logic [DATA_WIDTH-1:0] lit_data,
  output logic [CNT_W-1:0]      depth,
  output logic                  result_valid,
  output logic                  err_underflow,
  output logic                  err_overflow,
  input  logic                  err_clr,
  output logic [2:0]            fsm_state
);

  // Handshake: a token transfers on any rising edge where tok_valid && tok_ready;
  // tok_ready is high only in IDLE, and an accepted token is always consumed,
  // even when it is rejected for under/overflow.

  logic [2:0] state;
  ctrl_t      ctrl;
  logic       accept;
  logic       is_empty;
  logic       lt2;
  logic       is_full;
  logic       ovf_set;
  logic       unf_set;

  assign ctrl         = decode_ctrl(state);
  assign stk_push     = ctrl.stk_push;
  assign stk_pop      = ctrl.stk_pop;
  assign reg1_en      = ctrl.reg1_en;
  assign reg2_en      = ctrl.reg2_en;
  assign mux_sel      = ctrl.mux_sel;
  assign result_valid = ctrl.result_valid;
  assign fsm_state    = state;

  assign tok_ready = (state == ST_IDLE);
  assign accept    = tok_valid && tok_ready;
  assign ovf_set   = accept && !tok_is_op && is_full;
  assign unf_set   = accept && tok_is_op && (is_empty || lt2);

  rpn_depth_counter #(
    .CNT_W     (CNT_W),
    .MAX_COUNT (STACK_DEPTH)
  ) u_depth (
    .clk      (clk),
    .rst      (rst),
    .inc      (ctrl.stk_push),
    .dec      (ctrl.stk_pop),
    .count    (depth),
    .is_empty (is_empty),
    .lt2      (lt2),
    .is_full  (is_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      lit_data      <= '0;
      alu_opcode    <= OP_ADD;
      err_underflow <= 1'b0;
      err_overflow  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept && !tok_is_op && !is_full) begin
            lit_data <= tok_data;
            state    <= ST_PUSH_L;
          end else if (accept && tok_is_op && !unf_set) begin
            alu_opcode <= tok_opcode;
            state      <= ST_POP_A;
          end
        end
        ST_POP_A:  state <= ST_POP_B;
        ST_POP_B:  state <= ST_PUSH_R;
        ST_PUSH_L: state <= ST_IDLE;
        ST_PUSH_R: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase

      // A fresh error outranks a simultaneous clear.
      if (ovf_set) begin
        err_overflow <= 1'b1;
      end else if (err_clr) begin
        err_overflow <= 1'b0;
      end
      if (unf_set) begin
        err_underflow <= 1'b1;
      end else if (err_clr) begin
        err_underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rpn_sequencer.sv
// Bench for rpn_sequencer: a behavioural stack/ALU datapath around the DUT, a list-based
// RPN reference model feeding an expected-push queue, and a monitor scoring every push.
module tb_rpn_sequencer;
  import rpn_pkg::*;

  localparam int DW = 4;
  localparam int SD = 32;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          tok_valid;
  logic          tok_ready;
  logic          tok_is_op;
  logic [1:0]    tok_opcode;
  logic [DW-1:0] tok_data;
  logic          stk_push;
  logic          stk_pop;
  logic          reg1_en;
  logic          reg2_en;
  logic          mux_sel;
  logic [1:0]    alu_opcode;
  logic [DW-1:0] lit_data;
  logic [CW-1:0] depth;
  logic          result_valid;
  logic          err_underflow;
  logic          err_overflow;
  logic          err_clr;
  logic [2:0]    fsm_state;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  rpn_sequencer #(.DATA_WIDTH(DW), .STACK_DEPTH(SD), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .tok_valid     (tok_valid),
    .tok_ready     (tok_ready),
    .tok_is_op     (tok_is_op),
    .tok_opcode    (tok_opcode),
    .tok_data      (tok_data),
    .stk_push      (stk_push),
    .stk_pop       (stk_pop),
    .reg1_en       (reg1_en),
    .reg2_en       (reg2_en),
    .mux_sel       (mux_sel),
    .alu_opcode    (alu_opcode),
    .lit_data      (lit_data),
    .depth         (depth),
    .result_valid  (result_valid),
    .err_underflow (err_underflow),
    .err_overflow  (err_overflow),
    .err_clr       (err_clr),
    .fsm_state     (fsm_state)
  );

  // ---------------- scoreboard state ----------------
  int            n_checks = 0;
  int            n_pass   = 0;
  logic [DW-1:0] exp_q[$];
  int            ref_stk[$];
  bit            ref_unf;
  bit            ref_ovf;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // a = later-pushed operand, b = earlier-pushed operand
  function automatic logic [DW-1:0] alu_ref(input logic [1:0] op, input int a, input int b);
    int r;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      default: r = a | b;
    endcase
    return r[DW-1:0];
  endfunction

  // ---------------- behavioural datapath ----------------
  logic [DW-1:0] dp_stk[64];
  logic [5:0]    dp_sp;
  logic [DW-1:0] dp_reg1;
  logic [DW-1:0] dp_reg2;
  logic [DW-1:0] dp_top;

  assign dp_top = dp_stk[dp_sp - 6'd1];

  always @(posedge clk) begin
    if (rst) begin
      dp_sp <= '0;
    end else begin
      if (reg1_en) dp_reg1 <= dp_top;
      if (reg2_en) dp_reg2 <= alu_ref(alu_opcode, int'(dp_reg1), int'(dp_top));
      if (stk_pop) dp_sp <= dp_sp - 6'd1;
      if (stk_push) begin
        dp_stk[dp_sp] <= mux_sel ? dp_reg2 : lit_data;
        dp_sp         <= dp_sp + 6'd1;
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst && stk_push) begin
      chk("push_pop_excl", int'(stk_pop), 0);
      chk("result_valid_on_push", int'(result_valid), int'(mux_sel));
      if (exp_q.size() == 0) chk("unexpected_push", int'(stk_push), 0);
      else chk("push_value", int'(mux_sel ? dp_reg2 : lit_data), int'(exp_q.pop_front()));
    end else if (!rst && result_valid) begin
      chk("result_valid_without_push", int'(result_valid), 0);
    end
  end

  // ---------------- reference model ----------------
  task automatic model_token(input bit is_op, input logic [1:0] op, input logic [DW-1:0] data);
    int a, b;
    logic [DW-1:0] r;
    if (!is_op) begin
      if (ref_stk.size() == SD) ref_ovf = 1'b1;
      else begin
        ref_stk.push_back(int'(data));
        exp_q.push_back(data);
      end
    end else begin
      if (ref_stk.size() < 2) ref_unf = 1'b1;
      else begin
        a = ref_stk.pop_back();
        b = ref_stk.pop_back();
        r = alu_ref(op, a, b);
        ref_stk.push_back(int'(r));
        exp_q.push_back(r);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tok_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("ready_timeout", int'(tok_ready), 1);
  endtask

  task automatic send_token(input bit is_op, input logic [1:0] op, input logic [DW-1:0] data,
                            input bit clr);
    wait_ready();
    tok_valid  = 1'b1;
    tok_is_op  = is_op;
    tok_opcode = op;
    tok_data   = data;
    err_clr    = clr;
    if (clr) begin
      ref_unf = 1'b0;
      ref_ovf = 1'b0;
    end
    model_token(is_op, op, data);
    @(posedge clk);
    #1;
    tok_valid = 1'b0;
    err_clr   = 1'b0;
    tok_data  = DW'($urandom_range(0, 15));
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    err_clr = 1'b1;
    ref_unf = 1'b0;
    ref_ovf = 1'b0;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    wait_ready();
    chk({tag, "_depth"}, int'(depth), ref_stk.size());
    chk({tag, "_err_underflow"}, int'(err_underflow), int'(ref_unf));
    chk({tag, "_err_overflow"}, int'(err_overflow), int'(ref_ovf));
  endtask

  task automatic random_tokens(input int count, input int op_pct);
    bit is_op;
    for (int i = 0; i < count; i++) begin
      is_op = ($urandom_range(0, 99) < op_pct);
      send_token(is_op, 2'($urandom_range(0, 3)), DW'($urandom_range(0, 15)),
                 $urandom_range(0, 9) == 0);
      check_idle("rand");
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst        = 1'b1;
    tok_valid  = 1'b0;
    tok_is_op  = 1'b0;
    tok_opcode = '0;
    tok_data   = '0;
    err_clr    = 1'b0;
    ref_unf    = 1'b0;
    ref_ovf    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);

    chk("rst_tok_ready", int'(tok_ready), 1);
    chk("rst_depth", int'(depth), 0);
    chk("rst_strobes", int'({stk_push, stk_pop, reg1_en, reg2_en, mux_sel, result_valid}), 0);
    chk("rst_alu_opcode", int'(alu_opcode), 0);
    chk("rst_lit_data", int'(lit_data), 0);
    chk("rst_errs", int'({err_underflow, err_overflow}), 0);
    chk("rst_state", int'(fsm_state), int'(ST_IDLE));

    // Single literal: push one cycle after acceptance.
    send_token(1'b0, 2'b00, 4'd3, 1'b0);
    @(negedge clk);
    chk("lit_push", int'(stk_push), 1);
    chk("lit_mux_sel", int'(mux_sel), 0);
    chk("lit_data", int'(lit_data), 3);
    chk("lit_ready_low", int'(tok_ready), 0);
    chk("lit_depth_before", int'(depth), 0);
    @(negedge clk);
    chk("lit_depth_after", int'(depth), 1);

    // 3 5 + : three-cycle operator sequence.
    send_token(1'b0, 2'b00, 4'd5, 1'b0);
    check_idle("lit5");
    send_token(1'b1, OP_ADD, 4'd0, 1'b0);
    @(negedge clk);
    chk("popa_strobes", int'({reg1_en, stk_pop, stk_push, reg2_en}), 4'b1100);
    chk("popa_depth", int'(depth), 2);
    chk("popa_ready", int'(tok_ready), 0);
    @(negedge clk);
    chk("popb_strobes", int'({reg1_en, stk_pop, stk_push, reg2_en}), 4'b0101);
    chk("popb_depth", int'(depth), 1);
    chk("popb_ready", int'(tok_ready), 0);
    @(negedge clk);
    chk("pushr_strobes", int'({stk_push, stk_pop, mux_sel, result_valid}), 4'b1011);
    chk("pushr_depth", int'(depth), 0);
    chk("pushr_ready", int'(tok_ready), 0);
    chk("pushr_reg2", int'(dp_reg2), 8);
    @(negedge clk);
    chk("op_depth_after", int'(depth), 1);
    chk("op_ready_after", int'(tok_ready), 1);

    // Underflow with a single entry.
    send_token(1'b1, OP_SUB, 4'd0, 1'b0);
    @(negedge clk);
    chk("unf_flag", int'(err_underflow), 1);
    chk("unf_no_strobes", int'({stk_push, stk_pop}), 0);
    chk("unf_depth", int'(depth), 1);
    chk("unf_ready", int'(tok_ready), 1);

    // Clear, then set-wins-over-clear, then clear alone.
    pulse_clr();
    @(negedge clk);
    chk("clr_alone_1", int'(err_underflow), 0);
    send_token(1'b1, OP_AND, 4'd0, 1'b1);
    @(negedge clk);
    chk("set_beats_clr", int'(err_underflow), 1);
    pulse_clr();
    @(negedge clk);
    chk("clr_alone_2", int'(err_underflow), 0);

    // Fill to capacity, then overflow.
    while (ref_stk.size() < SD) send_token(1'b0, 2'b00, DW'($urandom_range(0, 15)), 1'b0);
    check_idle("full");
    send_token(1'b0, 2'b00, 4'd7, 1'b0);
    @(negedge clk);
    chk("ovf_no_push", int'(stk_push), 0);
    chk("ovf_flag", int'(err_overflow), 1);
    chk("ovf_depth", int'(depth), SD);
    chk("ovf_ready", int'(tok_ready), 1);

    // Randomised traffic: drain-biased, fill-biased, then balanced.
    random_tokens(150, 70);
    random_tokens(200, 25);
    random_tokens(100, 50);

    // Reset during POP_B aborts the operator.
    send_token(1'b0, 2'b00, 4'd9, 1'b0);
    send_token(1'b0, 2'b00, 4'd4, 1'b0);
    check_idle("pre_rst");
    send_token(1'b1, OP_OR, 4'd0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("mid_rst_in_popb", int'(fsm_state), int'(ST_POP_B));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    ref_stk.delete();
    exp_q.delete();
    ref_unf = 1'b0;
    ref_ovf = 1'b0;
    @(negedge clk);
    chk("mid_rst_state", int'(fsm_state), int'(ST_IDLE));
    chk("mid_rst_depth", int'(depth), 0);
    chk("mid_rst_strobes", int'({stk_push, stk_pop, reg1_en, reg2_en, mux_sel, result_valid}), 0);
    chk("mid_rst_ready", int'(tok_ready), 1);
    chk("mid_rst_errs", int'({err_underflow, err_overflow}), 0);
    repeat (4) begin
      @(negedge clk);
      chk("mid_rst_no_result", int'(result_valid), 0);
    end

    random_tokens(40, 40);
    wait_ready();
    chk("exp_q_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rpn_sequencer.md
Name: rpn_sequencer

Overview:
FSM controller that sequences the 4-bit RPN calculator datapath: stack, reg1, ALU, reg2 and the operand/result mux.
- Accepts one token per valid/ready handshake. A token is either a literal to push or an operator to apply.
- Expands each token into cycle-by-cycle control strobes.
- Tracks stack depth and rejects tokens that would underflow or overflow the stack.
- Replaces the ROM-driven control unit; sits between the token source (keypad/host) and the datapath.

Parameters:
DATA_WIDTH, 4, operand/result width
STACK_DEPTH, 32, capacity of the attached stack
CNT_W, 6, depth counter width; must satisfy 2**CNT_W > STACK_DEPTH

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
tok_valid  in  1  token offered
tok_ready  out  1  sequencer can accept a token this cycle
tok_is_op  in  1  1 = operator, 0 = literal
tok_opcode  in  2  ALU opcode, meaningful when tok_is_op=1
tok_data  in  DATA_WIDTH  literal value, meaningful when tok_is_op=0
stk_push  out  1  stack push strobe
stk_pop  out  1  stack pop strobe
reg1_en  out  1  reg1 capture enable
reg2_en  out  1  reg2 capture enable
mux_sel  out  1  0 = literal path, 1 = reg2 result path
alu_opcode  out  2  held opcode of the operator in progress
lit_data  out  DATA_WIDTH  latched literal, drives mux input a
depth  out  CNT_W  current number of stack entries
result_valid  out  1  one-cycle pulse while a result is being pushed
err_underflow  out  1  sticky: operator arrived with depth<2
err_overflow  out  1  sticky: literal arrived with depth==STACK_DEPTH
err_clr  in  1  clears both sticky error flags

Behaviour:
- Datapath contract: stack top is visible combinationally; push/pop take effect at the clock edge; reg1/reg2 capture at the edge while their enable is high.
- Reset: state=IDLE, depth=0, all strobes 0, alu_opcode=0, lit_data=0, both error flags 0. Reset mid-sequence aborts immediately. The controller does not clear stack contents; depth=0 makes them unreachable.
- States: IDLE, PUSH_L, POP_A, POP_B, PUSH_R. Strobes are decoded from state only (Moore).
- tok_ready=1 only in IDLE. A token is accepted when tok_valid && tok_ready.
- Literal accept, depth<STACK_DEPTH:
  - latch tok_data into lit_data; go to PUSH_L.
  - PUSH_L: stk_push=1, mux_sel=0, depth+1, then IDLE.
  - Latency is 1 cycle after acceptance.
- Literal accept, depth==STACK_DEPTH: token consumed, no strobes, err_overflow<=1, stay in IDLE.
- Operator accept, depth>=2: latch tok_opcode into alu_opcode, then run three states.
  - POP_A: reg1_en=1, stk_pop=1, depth-1. reg1 captures the most-recent operand.
  - POP_B: reg2_en=1, stk_pop=1, depth-1. reg2 captures ALU(reg1, new top), i.e. a = later-pushed operand, b = earlier-pushed operand.
  - PUSH_R: stk_push=1, mux_sel=1, result_valid=1, depth+1, then IDLE.
  - Net depth change is -1. Total latency is 3 cycles; the next token can be accepted in the 4th cycle.
- Operator accept, depth<2: token consumed, no strobes, err_underflow<=1, stay in IDLE.
- stk_push and stk_pop are never high in the same cycle. Depth never wraps: it is bounded to 0..STACK_DEPTH by the accept checks.
- Error flags: set in the same edge as the offending accept and held until err_clr or rst. If a set and err_clr coincide, the set wins.
- mux_sel is 0 outside PUSH_R. alu_opcode holds its value until the next operator is accepted.

Decomposition:
- Package rpn_pkg:
  - state enum: IDLE, PUSH_L, POP_A, POP_B, PUSH_R
  - opcode constants: OP_ADD=2'b00, OP_SUB=2'b01, OP_AND=2'b10, OP_OR=2'b11
  - mux select constants: SEL_LIT=0, SEL_RES=1
- Sub-module rpn_depth_counter: saturating up/down counter with inc/dec inputs and is_empty, lt2 and is_full compares. The sequencer instantiates it once.

Test Plan:
1. rst, then literal 3 → tok_ready=1 at accept; next cycle stk_push=1, mux_sel=0, lit_data=3; depth goes 0→1.
2. Literals 3 then 5, then operator OP_ADD → consecutive cycles show POP_A (reg1_en, pop), POP_B (reg2_en, pop), PUSH_R (push, mux_sel=1, result_valid=1); depth 2→1→0→1; tok_ready low for 3 cycles; reg2=8 in the datapath.
3. With depth=1, send an operator → err_underflow=1 next cycle; no push/pop; depth stays 1; tok_ready stays 1.
4. 32 literals, then a 33rd literal → depth=32; err_overflow=1; no stk_push for the 33rd.
5. During POP_B assert rst for one cycle → next cycle state IDLE, depth=0, all strobes 0, result_valid never pulses.
6. err_clr asserted in the same cycle as an underflowing operator accept → err_underflow remains 1. err_clr alone the following cycle → flag clears to 0.
